// File: rtl/pipe_trace_buffer_if.sv
// WB-stage tap and indexed readout bundle for pipe_trace_buffer.
// Defining TRACE_MEMWR_EN adds the MEM-stage store tap (mem_*).
interface pipe_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              wb_valid;
    logic [4:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] wb_pc;
    logic [DATA_W-1:0] wb_instr;
`ifdef TRACE_MEMWR_EN
    logic              mem_write;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_pc;
`endif
    // Readout handshake: a request (rd_en with rd_idx) is accepted on every
    // clock with no back-pressure; rd_valid pulses exactly one cycle later and
    // qualifies rd_pc/rd_instr/rd_reg/rd_wdata/rd_kind for that cycle only.
    logic              rd_en;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_instr;
    logic [4:0]        rd_reg;
    logic [DATA_W-1:0] rd_wdata;
    logic              rd_kind;

    modport master (
`ifdef TRACE_MEMWR_EN
        output mem_write, mem_addr, mem_wdata, mem_pc,
`endif
        output wb_valid, wb_reg, wb_data, wb_pc, wb_instr, rd_en, rd_idx,
        input  rd_valid, rd_pc, rd_instr, rd_reg, rd_wdata, rd_kind
    );

    modport slave (
`ifdef TRACE_MEMWR_EN
        input  mem_write, mem_addr, mem_wdata, mem_pc,
`endif
        input  wb_valid, wb_reg, wb_data, wb_pc, wb_instr, rd_en, rd_idx,
        output rd_valid, rd_pc, rd_instr, rd_reg, rd_wdata, rd_kind
    );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Circular writeback-trace buffer captured around a PC trigger, with indexed readout.
// Optional macro TRACE_MEMWR_EN also records MEM-stage stores (kind=1).
module pipe_trace_buffer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6,
    parameter int POST_COUNT  = 16,
    parameter int CYCLE_LIMIT = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_pc,
    pipe_trace_buffer_if.slave tif,
    output logic [ADDR_W:0]   count,
    output logic [1:0]        state,
    output logic              triggered,
    output logic              timeout,
    output logic              overflow
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W+1:0] DEPTH_W  = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W+1:0] POST_W   = (ADDR_W+2)'(POST_COUNT);
    localparam logic [31:0]       LIMIT_M1 = (CYCLE_LIMIT == 0) ? 32'd0 : 32'(CYCLE_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [4:0]        rdst;
        logic [DATA_W-1:0] data;
`ifdef TRACE_MEMWR_EN
        logic              kind;
`endif
    } entry_t;

    state_t            st;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr1;
    logic [ADDR_W:0]   post_cnt;
    logic [31:0]       cycle_cnt;
    entry_t            mem [DEPTH];

    logic              capturing, rec_wb, trig_hit, limit_hit, drop;
    logic              we0;
    entry_t            e0;
    logic [1:0]        n_wr;
    logic [ADDR_W+1:0] cnt_sum, post_sum;
`ifdef TRACE_MEMWR_EN
    logic              we1;
    entry_t            e1;
`endif

    assign capturing = (st == S_ARMED) || (st == S_CAPTURE);
    assign rec_wb    = capturing && tif.wb_valid && (tif.wb_reg != 5'd0);
    assign trig_hit  = (st == S_ARMED) && rec_wb && (tif.wb_pc == trig_pc);
    assign limit_hit = (CYCLE_LIMIT != 0) && (cycle_cnt == LIMIT_M1);
    // Arm discards the concurrent record; an untriggered ARMED timeout stores nothing.
    assign drop      = arm || ((st == S_ARMED) && !trig_hit && limit_hit);
    assign wr_ptr1   = wr_ptr + ADDR_W'(1);
    assign cnt_sum   = {1'b0, count} + {{ADDR_W{1'b0}}, n_wr};
    assign post_sum  = {1'b0, post_cnt} + {{ADDR_W{1'b0}}, n_wr};
    assign state     = st;

    always_comb begin
        e0.pc    = tif.wb_pc;
        e0.instr = tif.wb_instr;
        e0.rdst  = tif.wb_reg;
        e0.data  = tif.wb_data;
`ifdef TRACE_MEMWR_EN
        e0.kind  = 1'b0;
        e1       = e0;
        we0      = rec_wb && !drop;
        we1      = 1'b0;
        // A store in the same cycle takes wr_ptr; the WB record follows it.
        if (capturing && tif.mem_write) begin
            e0.pc    = tif.mem_pc;
            e0.instr = tif.mem_addr;
            e0.rdst  = 5'd0;
            e0.data  = tif.mem_wdata;
            e0.kind  = 1'b1;
            we0      = !drop;
            we1      = rec_wb && !drop;
        end
        n_wr = {1'b0, we0} + {1'b0, we1};
`else
        we0  = rec_wb && !drop;
        n_wr = {1'b0, we0};
`endif
    end

    always_ff @(posedge clk) begin
        if (we0) mem[wr_ptr] <= e0;
`ifdef TRACE_MEMWR_EN
        if (we1) mem[wr_ptr1] <= e1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            cycle_cnt <= '0;
            triggered <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
        end else if (arm) begin
            st        <= trig_en ? S_ARMED : S_CAPTURE;
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            cycle_cnt <= '0;
            triggered <= !trig_en;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (n_wr != 2'd0) begin
                wr_ptr <= (n_wr == 2'd2) ? wr_ptr1 + ADDR_W'(1) : wr_ptr1;
                if (cnt_sum > DEPTH_W) begin
                    count    <= DEPTH_W[ADDR_W:0];
                    overflow <= 1'b1;
                end else begin
                    count <= cnt_sum[ADDR_W:0];
                end
            end
            case (st)
                S_ARMED: begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                    if (trig_hit) begin
                        triggered <= 1'b1;
                        post_cnt  <= (ADDR_W+1)'(1);
                        st        <= (POST_COUNT == 1) ? S_DONE : S_CAPTURE;
                    end else if (limit_hit) begin
                        timeout <= 1'b1;
                        st      <= S_DONE;
                    end
                end
                S_CAPTURE: begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                    post_cnt  <= post_sum[ADDR_W:0];
                    if (post_sum >= POST_W) st <= S_DONE;
                    if (limit_hit) begin
                        timeout <= 1'b1;
                        st      <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Index 0 is the oldest live entry; indices past count read back as zero.
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hit;
    entry_t            rd_q;

    assign rd_addr = wr_ptr - count[ADDR_W-1:0] + tif.rd_idx;
    assign rd_hit  = ({1'b0, tif.rd_idx} < count);

    always_ff @(posedge clk) begin
        if (reset) begin
            tif.rd_valid <= 1'b0;
            rd_q         <= '0;
        end else begin
            tif.rd_valid <= tif.rd_en;
            if (tif.rd_en) rd_q <= rd_hit ? mem[rd_addr] : '0;
        end
    end

    assign tif.rd_pc    = rd_q.pc;
    assign tif.rd_instr = rd_q.instr;
    assign tif.rd_reg   = rd_q.rdst;
    assign tif.rd_wdata = rd_q.data;
`ifdef TRACE_MEMWR_EN
    assign tif.rd_kind  = rd_q.kind;
`else
    assign tif.rd_kind  = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Self-checking bench for pipe_trace_buffer: status checks plus a readout scoreboard.
// The MEM-store case is exercised only when TRACE_MEMWR_EN is defined.
module tb_pipe_trace_buffer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int POST   = 16;
    localparam int CL     = 100;
    localparam int EW     = 3 * DATA_W + 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              arm = 1'b0;
    logic              trig_en = 1'b0;
    logic [DATA_W-1:0] trig_pc = '0;
    logic [ADDR_W:0]   count;
    logic [1:0]        state;
    logic              triggered, timeout, overflow;

    pipe_trace_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) tif ();

    pipe_trace_buffer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .POST_COUNT(POST), .CYCLE_LIMIT(CL)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .tif(tif), .count(count), .state(state), .triggered(triggered),
        .timeout(timeout), .overflow(overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] m_mem [DEPTH];
    int m_wr = 0;
    int m_cnt = 0;
    logic [EW-1:0] mon_got;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model of the stored trace
    function automatic void model_clear();
        m_wr  = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_store(input logic [EW-1:0] e);
        m_mem[m_wr] = e;
        m_wr = (m_wr + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
    endfunction

    function automatic logic [EW-1:0] model_get(input int idx);
        if (idx >= m_cnt) return '0;
        return m_mem[(m_wr - m_cnt + idx + DEPTH) % DEPTH];
    endfunction

    // driver tasks
    task automatic arm_cap(input logic te, input logic [31:0] tpc);
        trig_en = te;
        trig_pc = tpc;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        model_clear();
    endtask

    task automatic retire(input logic [4:0] r, input logic [31:0] pc, input logic [31:0] d, input bit keep);
        logic [31:0] ins;
        ins = $urandom;
        tif.wb_valid = 1'b1;
        tif.wb_reg   = r;
        tif.wb_pc    = pc;
        tif.wb_data  = d;
        tif.wb_instr = ins;
        tick();
        tif.wb_valid = 1'b0;
        if (keep) model_store({pc, ins, r, d, 1'b0});
    endtask

    task automatic read_one(input int idx);
        tif.rd_idx = ADDR_W'(idx);
        tif.rd_en  = 1'b1;
        exp_q.push_back(model_get(idx));
        tick();
        tif.rd_en = 1'b0;
    endtask

    // scoreboard: every rd_valid pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (tif.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                mon_got = {tif.rd_pc, tif.rd_instr, tif.rd_reg, tif.rd_wdata, tif.rd_kind};
                check("rd_entry", mon_got, exp_q.pop_front());
            end
        end
    end

    initial begin
        tif.wb_valid = 1'b0;
        tif.wb_reg   = '0;
        tif.wb_data  = '0;
        tif.wb_pc    = '0;
        tif.wb_instr = '0;
        tif.rd_en    = 1'b0;
        tif.rd_idx   = '0;
`ifdef TRACE_MEMWR_EN
        tif.mem_write = 1'b0;
        tif.mem_addr  = '0;
        tif.mem_wdata = '0;
        tif.mem_pc    = '0;
`endif
        tick();
        tick();
        reset = 1'b0;
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_trig", triggered, 0);
        check("rst_tmo", timeout, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rdv", tif.rd_valid, 0);
        check("rst_rdata", {tif.rd_pc, tif.rd_instr, tif.rd_reg, tif.rd_wdata, tif.rd_kind}, 0);

        // immediate trigger, $0 write not stored
        arm_cap(1'b0, 32'h0);
        check("imm_state", state, 2);
        check("imm_trig", triggered, 1);
        retire(5'd8, 32'h0, 32'h5, 1'b1);
        retire(5'd9, 32'h4, 32'h7, 1'b1);
        retire(5'd0, 32'h8, 32'h9, 1'b0);
        check("imm_count", count, 2);
        check("imm_state2", state, 2);
        read_one(0);
        read_one(1);
        read_one(5);

        // pre-trigger wrap, overflow, trigger, post-count stop
        arm_cap(1'b1, 32'h104);
        check("arm_state", state, 1);
        check("arm_trig", triggered, 0);
        for (int i = 0; i < 85; i++) begin
            retire(5'((i % 31) + 1), 32'(4 * i), $urandom, i <= 80);
            if (i == 63) begin
                check("ovf_64", overflow, 0);
                check("cnt_64", count, 64);
            end
            if (i == 64) begin
                check("ovf_65", overflow, 1);
                check("cnt_sat", count, 64);
                check("pre_trig_state", state, 1);
            end
            if (i == 65) begin
                check("trig_state", state, 2);
                check("trig_flag", triggered, 1);
            end
            if (i == 79) check("post15_state", state, 2);
            if (i == 80) check("post16_state", state, 3);
        end
        check("done_state", state, 3);
        check("done_count", count, 64);
        check("done_tmo", timeout, 0);
        for (int i = 0; i < DEPTH; i++) read_one(i);
        check("done_hold", state, 3);

        // cycle-limit stop without trigger; arm-cycle and timeout-cycle records dropped
        trig_en = 1'b1;
        trig_pc = 32'hFFFF_FFF0;
        tif.wb_valid = 1'b1;
        tif.wb_reg   = 5'd3;
        tif.wb_pc    = 32'h1000;
        tif.wb_data  = 32'h0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tif.wb_valid = 1'b0;
        model_clear();
        for (int k = 1; k <= CL; k++) begin
            retire(5'd3, 32'h1000 + 32'(4 * k), 32'(k), k < CL);
            if (k == CL - 1) begin
                check("lim_pre_state", state, 1);
                check("lim_pre_tmo", timeout, 0);
            end
        end
        check("lim_state", state, 3);
        check("lim_tmo", timeout, 1);
        check("lim_trig", triggered, 0);
        check("lim_count", count, 64);
        check("lim_ovf", overflow, 1);
        read_one(0);
        read_one(17);
        read_one(63);

        // re-arm mid-capture with a concurrent (even trigger-matching) record
        arm_cap(1'b0, 32'h0);
        for (int k = 0; k < 10; k++) retire(5'(k + 1), 32'h200 + 32'(4 * k), 32'(k), 1'b1);
        check("cap10_count", count, 10);
        check("cap10_state", state, 2);
        trig_en = 1'b1;
        trig_pc = 32'h500;
        tif.wb_valid = 1'b1;
        tif.wb_reg   = 5'd7;
        tif.wb_pc    = 32'h500;
        tif.wb_data  = 32'hDEAD;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tif.wb_valid = 1'b0;
        model_clear();
        check("rearm_count", count, 0);
        check("rearm_state", state, 1);
        check("rearm_trig", triggered, 0);
        retire(5'd7, 32'h500, 32'hBEEF, 1'b1);
        check("retrig_state", state, 2);
        check("retrig_count", count, 1);
        read_one(0);
        read_one(1);

        // reset during capture, with a read request in the reset cycle
        retire(5'd4, 32'h504, 32'h1, 1'b1);
        retire(5'd5, 32'h508, 32'h2, 1'b1);
        check("mid_state", state, 2);
        reset = 1'b1;
        tif.rd_en  = 1'b1;
        tif.rd_idx = '0;
        tick();
        reset = 1'b0;
        tif.rd_en = 1'b0;
        model_clear();
        check("mrst_state", state, 0);
        check("mrst_count", count, 0);
        check("mrst_trig", triggered, 0);
        check("mrst_tmo", timeout, 0);
        check("mrst_ovf", overflow, 0);
        check("mrst_rdv", tif.rd_valid, 0);
        read_one(0);

`ifdef TRACE_MEMWR_EN
        // store and writeback in one cycle: mem entry first, then WB entry
        arm_cap(1'b0, 32'h0);
        tif.mem_write = 1'b1;
        tif.mem_addr  = 32'h10;
        tif.mem_wdata = 32'hAB;
        tif.mem_pc    = 32'h40;
        model_store({32'h40, 32'h10, 5'd0, 32'hAB, 1'b1});
        retire(5'd16, 32'h44, 32'h55, 1'b1);
        tif.mem_write = 1'b0;
        check("mw_count", count, 2);
        read_one(0);
        read_one(1);
`endif

        tick();
        tick();
        check("rd_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
